reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//   Circular in-order reorder buffer between the dispatcher and the register file / LSB. Allocates one
//   entry per dispatched instruction and collects results from the reservation station and LSB write-back
//   buses. Retires at most one ready entry per cycle from the head and detects branch/jalr redirects.
//   On a redirect it raises flush_signal and flush_pc for all stages.
// PARAMETERS
//   RoB_WIDTH  4               index width
//   RoB_SIZE   1<<RoB_WIDTH    entry count
//   NON_DEP    1<<RoB_WIDTH    "no dependency" tag returned by queries for ready operands
// PORTS
//   clk_in            in   1   clock, all state on posedge
//   rst_in            in   1   asynchronous, active-low reset
//   rdy_in            in   1   0 = hold all state, all strobes 0
//   alloc_en          in   1   dispatcher requests an entry; ignored when isFull
//   alloc_type        in   2   0 REG, 1 BRANCH, 2 JALR, 3 STORE
//   alloc_rd          in   5   destination register (REG/JALR)
//   alloc_pc          in   32  instruction pc
//   alloc_pred_taken  in   1   BRANCH predicted direction
//   alloc_target      in   32  BRANCH taken target (pc+imm)
//   alloc_ready       in   1   result known at dispatch (lui/auipc/jal)
//   alloc_value       in   32  value when alloc_ready=1
//   alloc_index       out  RoB_WIDTH  tail index = tag of the entry allocated this cycle
//   RS_update_en/index/data   in 1/RoB_WIDTH/32  RS write-back
//   LSB_update_en/index/data  in 1/RoB_WIDTH/32  LSB write-back (load data, store ready)
//   query_j_index, query_k_index  in  RoB_WIDTH  operand tags being looked up
//   query_j_ready, query_k_ready  out 1   entry ready (combinational)
//   query_j_data,  query_k_data   out 32  entry value (combinational)
//   commit_en         out  1   one-cycle strobe: head entry retired
//   commit_index      out  RoB_WIDTH  retired tag (regfile clears matching dependency)
//   commit_rd         out  5   0 for BRANCH/STORE
//   commit_data       out  32  value written to commit_rd
//   commit_store_en   out  1   head STORE retired; LSB may write memory
//   flush_signal      out  1   one-cycle redirect strobe
//   flush_pc          out  32  redirect pc
//   isFull, isEmpty   out  1   count==RoB_SIZE / count==0
// BEHAVIOUR
//   - Reset (async, rst_in=0): head=tail=0, count=0, all entries invalid; all strobes, data and flush_pc 0.
//   - Entry fields: valid, ready, type, rd, value, pc, pred_taken, target. head/tail wrap mod RoB_SIZE.
//     count is RoB_WIDTH+1 bits.
//   - Alloc: alloc_en && !isFull -> entry[tail] written, ready=alloc_ready, tail+1, count+1.
//     alloc_index is valid in the same cycle.
//   - Write-back: update_en to a valid entry -> value=data, ready=1 next edge.
//     An update to an invalid entry is ignored. If both ports hit the same index, RS wins.
//   - Query: combinational. ready=1 if the entry is ready, or if either write-back port targets it
//     this cycle (bypass, RS first). Otherwise data=0 and ready=0.
//   - Commit (registered): head valid && ready -> next cycle commit_en=1, head+1, count-1.
//     A result written in cycle N retires no earlier than edge N+1.
//       REG:    commit_rd=rd, commit_data=value.
//       STORE:  commit_store_en=1, commit_rd=0.
//       BRANCH: value[0] = actual taken. If value[0] != pred_taken, flush_signal=1 with
//               flush_pc = taken ? target : pc+4.
//       JALR:   commit_rd=rd, commit_data=pc+4, flush_signal=1, flush_pc=value&~1 (always).
//   - Flush: the edge that raises flush_signal also invalidates all entries and sets head=tail=count=0.
//     alloc_en in that cycle is dropped. The flushing instruction itself commits (commit_en=1 the same cycle).
//   - Simultaneous alloc+commit: count unchanged. Alloc while full with commit in the same cycle is still
//     refused (isFull is evaluated before the edge).
//   - Strobes (commit_en, commit_store_en, flush_signal) are high for exactly one cycle.
//     commit_rd/data hold between strobes.
//   - rdy_in=0: no alloc, write-back or commit; strobes 0.
// TESTING
//   1 Reset mid-run with 5 entries: drop rst_in -> count=0, isEmpty=1, commit_en=0 immediately (async).
//   2 Fill: 16 allocs of REG -> isFull=1 after the 16th. A 17th is ignored. alloc_index wraps 15->0 after commits.
//   3 Out-of-order write-back to tags 2,0,1 (data 0x22,0x00,0x11) -> commits in order 0,1,2, one per cycle.
//   4 BRANCH pc=0x100, pred_taken=0, target=0x140, RS writes 1 -> flush_signal=1, flush_pc=0x140; ROB empty.
//   5 JALR rd=x1 pc=0x200, RS writes 0x305 -> commit_rd=1, commit_data=0x204, flush_pc=0x304.
//   6 Same-cycle RS write to tag 3 (0xAB) with query_j_index=3 -> query_j_ready=1, query_j_data=0xAB.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Dispatcher/write-back/commit bundle for the reorder buffer.
// The ROB uses the slave modport and the dispatcher/regfile/LSB side uses master.
// alloc_*, *_update_* and query_*_index flow into the ROB; tags, query results and commit/flush flow out.
interface reorder_buffer_if #(
    parameter int RoB_WIDTH = 4
);
    // dispatcher allocation
    logic                 alloc_en;
    logic [1:0]           alloc_type;
    logic [4:0]           alloc_rd;
    logic [31:0]          alloc_pc;
    logic                 alloc_pred_taken;
    logic [31:0]          alloc_target;
    logic                 alloc_ready;
    logic [31:0]          alloc_value;
    logic [RoB_WIDTH-1:0] alloc_index;
    // write-back buses
    logic                 RS_update_en;
    logic [RoB_WIDTH-1:0] RS_update_index;
    logic [31:0]          RS_update_data;
    logic                 LSB_update_en;
    logic [RoB_WIDTH-1:0] LSB_update_index;
    logic [31:0]          LSB_update_data;
    // operand lookups
    logic [RoB_WIDTH-1:0] query_j_index;
    logic [RoB_WIDTH-1:0] query_k_index;
    logic                 query_j_ready;
    logic                 query_k_ready;
    logic [31:0]          query_j_data;
    logic [31:0]          query_k_data;
    // retirement / redirect
    logic                 commit_en;
    logic [RoB_WIDTH-1:0] commit_index;
    logic [4:0]           commit_rd;
    logic [31:0]          commit_data;
    logic                 commit_store_en;
    logic                 flush_signal;
    logic [31:0]          flush_pc;
    logic                 isFull;
    logic                 isEmpty;

    modport slave (
        input  alloc_en, alloc_type, alloc_rd, alloc_pc, alloc_pred_taken,
               alloc_target, alloc_ready, alloc_value,
               RS_update_en, RS_update_index, RS_update_data,
               LSB_update_en, LSB_update_index, LSB_update_data,
               query_j_index, query_k_index,
        output alloc_index, query_j_ready, query_k_ready, query_j_data, query_k_data,
               commit_en, commit_index, commit_rd, commit_data, commit_store_en,
               flush_signal, flush_pc, isFull, isEmpty
    );

    modport master (
        output alloc_en, alloc_type, alloc_rd, alloc_pc, alloc_pred_taken,
               alloc_target, alloc_ready, alloc_value,
               RS_update_en, RS_update_index, RS_update_data,
               LSB_update_en, LSB_update_index, LSB_update_data,
               query_j_index, query_k_index,
        input  alloc_index, query_j_ready, query_k_ready, query_j_data, query_k_data,
               commit_en, commit_index, commit_rd, commit_data, commit_store_en,
               flush_signal, flush_pc, isFull, isEmpty
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail, collects RS/LSB results, retires one entry from head.
// Latency: alloc_index/queries combinational; a result written in cycle N commits at edge N+1 at the earliest.
// Backpressure: alloc_en is dropped while isFull (and in a flushing cycle); rdy_in=0 freezes all state.
// Ports: clk_in, rst_in (async active-low), rdy_in, bus (reorder_buffer_if.slave: alloc, write-back,
//        operand query, commit and flush signals).
module reorder_buffer #(
    parameter int RoB_WIDTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    reorder_buffer_if.slave  bus
);
    localparam int RoB_SIZE = 1 << RoB_WIDTH;
    localparam logic [RoB_WIDTH-1:0] IDX_ONE  = RoB_WIDTH'(1);
    localparam logic [RoB_WIDTH:0]   CNT_ONE  = (RoB_WIDTH + 1)'(1);
    localparam logic [RoB_WIDTH:0]   CNT_FULL = {1'b1, {RoB_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        T_REG    = 2'd0,
        T_BRANCH = 2'd1,
        T_JALR   = 2'd2,
        T_STORE  = 2'd3
    } rob_type_e;

    typedef struct packed {
        logic        valid;
        logic        ready;
        rob_type_e   typ;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] target;
    } entry_t;

    entry_t               ent_q [RoB_SIZE];
    entry_t               ent_d [RoB_SIZE];
    logic [RoB_WIDTH-1:0] head_q, head_d;
    logic [RoB_WIDTH-1:0] tail_q, tail_d;
    logic [RoB_WIDTH:0]   count_q, count_d;

    logic                 commit_en_q, commit_en_d;
    logic [RoB_WIDTH-1:0] commit_index_q, commit_index_d;
    logic [4:0]           commit_rd_q, commit_rd_d;
    logic [31:0]          commit_data_q, commit_data_d;
    logic                 commit_store_en_q, commit_store_en_d;
    logic                 flush_signal_q, flush_signal_d;
    logic [31:0]          flush_pc_q, flush_pc_d;

    logic   is_full;
    logic   is_empty;
    logic   do_alloc;
    logic   do_commit;
    entry_t head_e;

    assign is_full  = (count_q == CNT_FULL);
    assign is_empty = (count_q == '0);

    always_comb begin
        ent_d             = ent_q;
        head_d            = head_q;
        tail_d            = tail_q;
        count_d           = count_q;
        commit_en_d       = 1'b0;
        commit_store_en_d = 1'b0;
        flush_signal_d    = 1'b0;
        commit_index_d    = commit_index_q;
        commit_rd_d       = commit_rd_q;
        commit_data_d     = commit_data_q;
        flush_pc_d        = flush_pc_q;
        do_alloc          = 1'b0;
        do_commit         = 1'b0;
        head_e            = ent_q[head_q];

        if (rdy_in) begin
            do_alloc  = bus.alloc_en && !is_full;
            do_commit = head_e.valid && head_e.ready;

            // LSB first so that an RS write to the same tag overrides it.
            if (bus.LSB_update_en && ent_q[bus.LSB_update_index].valid) begin
                ent_d[bus.LSB_update_index].value = bus.LSB_update_data;
                ent_d[bus.LSB_update_index].ready = 1'b1;
            end
            if (bus.RS_update_en && ent_q[bus.RS_update_index].valid) begin
                ent_d[bus.RS_update_index].value = bus.RS_update_data;
                ent_d[bus.RS_update_index].ready = 1'b1;
            end

            if (do_alloc) begin
                ent_d[tail_q].valid      = 1'b1;
                ent_d[tail_q].ready      = bus.alloc_ready;
                ent_d[tail_q].typ        = rob_type_e'(bus.alloc_type);
                ent_d[tail_q].rd         = bus.alloc_rd;
                ent_d[tail_q].value      = bus.alloc_value;
                ent_d[tail_q].pc         = bus.alloc_pc;
                ent_d[tail_q].pred_taken = bus.alloc_pred_taken;
                ent_d[tail_q].target     = bus.alloc_target;
                tail_d                   = tail_q + IDX_ONE;
            end

            if (do_commit) begin
                ent_d[head_q].valid = 1'b0;
                ent_d[head_q].ready = 1'b0;
                head_d              = head_q + IDX_ONE;
                commit_en_d         = 1'b1;
                commit_index_d      = head_q;
                commit_rd_d         = 5'd0;
                commit_data_d       = head_e.value;
                case (head_e.typ)
                    T_REG:   commit_rd_d = head_e.rd;
                    T_STORE: commit_store_en_d = 1'b1;
                    T_BRANCH: begin
                        // value[0] carries the resolved direction
                        if (head_e.value[0] != head_e.pred_taken) begin
                            flush_signal_d = 1'b1;
                            flush_pc_d     = head_e.value[0] ? head_e.target : head_e.pc + 32'd4;
                        end
                    end
                    T_JALR: begin
                        commit_rd_d    = head_e.rd;
                        commit_data_d  = head_e.pc + 32'd4;
                        flush_signal_d = 1'b1;
                        flush_pc_d     = {head_e.value[31:1], 1'b0};
                    end
                    default: ;
                endcase
            end

            case ({do_alloc, do_commit})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            // A redirect discards everything younger, including an alloc in this same cycle.
            if (flush_signal_d) begin
                for (int i = 0; i < RoB_SIZE; i++) begin
                    ent_d[i].valid = 1'b0;
                    ent_d[i].ready = 1'b0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RoB_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            commit_en_q       <= 1'b0;
            commit_index_q    <= '0;
            commit_rd_q       <= '0;
            commit_data_q     <= '0;
            commit_store_en_q <= 1'b0;
            flush_signal_q    <= 1'b0;
            flush_pc_q        <= '0;
        end else begin
            for (int i = 0; i < RoB_SIZE; i++) begin
                ent_q[i] <= ent_d[i];
            end
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            commit_en_q       <= commit_en_d;
            commit_index_q    <= commit_index_d;
            commit_rd_q       <= commit_rd_d;
            commit_data_q     <= commit_data_d;
            commit_store_en_q <= commit_store_en_d;
            flush_signal_q    <= flush_signal_d;
            flush_pc_q        <= flush_pc_d;
        end
    end

    // Operand lookup: stored result first, then same-cycle bypass from RS, then LSB.
    function automatic logic [32:0] lookup(
        input entry_t               e,
        input logic [RoB_WIDTH-1:0] q_idx,
        input logic                 byp_ok,
        input logic                 rs_en,
        input logic [RoB_WIDTH-1:0] rs_idx,
        input logic [31:0]          rs_dat,
        input logic                 lsb_en,
        input logic [RoB_WIDTH-1:0] lsb_idx,
        input logic [31:0]          lsb_dat
    );
        logic [32:0] res;
        res = '0;
        if (e.valid && e.ready)
            res = {1'b1, e.value};
        else if (byp_ok && rs_en && rs_idx == q_idx)
            res = {1'b1, rs_dat};
        else if (byp_ok && lsb_en && lsb_idx == q_idx)
            res = {1'b1, lsb_dat};
        return res;
    endfunction

    logic [32:0] q_j, q_k;

    assign q_j = lookup(ent_q[bus.query_j_index], bus.query_j_index, rdy_in,
                        bus.RS_update_en, bus.RS_update_index, bus.RS_update_data,
                        bus.LSB_update_en, bus.LSB_update_index, bus.LSB_update_data);
    assign q_k = lookup(ent_q[bus.query_k_index], bus.query_k_index, rdy_in,
                        bus.RS_update_en, bus.RS_update_index, bus.RS_update_data,
                        bus.LSB_update_en, bus.LSB_update_index, bus.LSB_update_data);

    assign bus.query_j_ready   = q_j[32];
    assign bus.query_j_data    = q_j[31:0];
    assign bus.query_k_ready   = q_k[32];
    assign bus.query_k_data    = q_k[31:0];
    assign bus.alloc_index     = tail_q;
    assign bus.isFull          = is_full;
    assign bus.isEmpty         = is_empty;
    assign bus.commit_en       = commit_en_q;
    assign bus.commit_index    = commit_index_q;
    assign bus.commit_rd       = commit_rd_q;
    assign bus.commit_data     = commit_data_q;
    assign bus.commit_store_en = commit_store_en_q;
    assign bus.flush_signal    = flush_signal_q;
    assign bus.flush_pc        = flush_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_reorder_buffer;
    logic clk;
    logic rst_n;
    logic rdy;
    int   n_chk;
    int   n_fail;

    reorder_buffer_if #(.RoB_WIDTH(4)) rob_bus ();

    reorder_buffer #(.RoB_WIDTH(4)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (rob_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one row = inputs for one cycle, outputs expected after the following edge
    typedef struct {
        int unsigned rdy, a_en, a_ty, a_rd, a_pc, a_pred, a_tgt, a_rdy, a_val;
        int unsigned wb, wb_idx, wb_dat;                 // wb: 0 none, 1 RS, 2 LSB
        int unsigned e_aidx;                             // alloc_index before the edge (if a_en)
        int unsigned e_ce, chk_c, chk_d, e_cidx, e_crd, e_cdat;
        int unsigned e_st, e_fl, e_fpc, e_empty;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rob_bus.alloc_en         = 1'b0;
        rob_bus.alloc_type       = 2'd0;
        rob_bus.alloc_rd         = 5'd0;
        rob_bus.alloc_pc         = 32'd0;
        rob_bus.alloc_pred_taken = 1'b0;
        rob_bus.alloc_target     = 32'd0;
        rob_bus.alloc_ready      = 1'b0;
        rob_bus.alloc_value      = 32'd0;
        rob_bus.RS_update_en     = 1'b0;
        rob_bus.RS_update_index  = 4'd0;
        rob_bus.RS_update_data   = 32'd0;
        rob_bus.LSB_update_en    = 1'b0;
        rob_bus.LSB_update_index = 4'd0;
        rob_bus.LSB_update_data  = 32'd0;
        rob_bus.query_j_index    = 4'd0;
        rob_bus.query_k_index    = 4'd0;
    endtask

    task automatic alloc_reg(input logic [4:0] rd);
        rob_bus.alloc_en    = 1'b1;
        rob_bus.alloc_type  = 2'd0;
        rob_bus.alloc_rd    = rd;
        rob_bus.alloc_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy   = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        logic [31:0] t;
        rdy                      = v.rdy[0];
        rob_bus.alloc_en         = v.a_en[0];
        t = v.a_ty;  rob_bus.alloc_type = t[1:0];
        t = v.a_rd;  rob_bus.alloc_rd   = t[4:0];
        rob_bus.alloc_pc         = v.a_pc;
        rob_bus.alloc_pred_taken = v.a_pred[0];
        rob_bus.alloc_target     = v.a_tgt;
        rob_bus.alloc_ready      = v.a_rdy[0];
        rob_bus.alloc_value      = v.a_val;
        t = v.wb_idx;
        rob_bus.RS_update_en     = (v.wb == 1);
        rob_bus.RS_update_index  = t[3:0];
        rob_bus.RS_update_data   = v.wb_dat;
        rob_bus.LSB_update_en    = (v.wb == 2);
        rob_bus.LSB_update_index = t[3:0];
        rob_bus.LSB_update_data  = v.wb_dat;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        //          rdy en ty rd pc     pr tgt    ar av  wb ix dat    aidx ce cc cd cidx crd cdat   st fl fpc    empty
        vecs[0]  = '{1, 1, 0, 5, 'h000, 0, 0,     0, 0,  0, 0, 0,     0,   0, 0, 0, 0,   0,  0,     0, 0, 0,     0};
        vecs[1]  = '{1, 1, 0, 6, 'h004, 0, 0,     0, 0,  0, 0, 0,     1,   0, 0, 0, 0,   0,  0,     0, 0, 0,     0};
        vecs[2]  = '{1, 1, 0, 7, 'h008, 0, 0,     0, 0,  0, 0, 0,     2,   0, 0, 0, 0,   0,  0,     0, 0, 0,     0};
        vecs[3]  = '{1, 0, 0, 0, 0,     0, 0,     0, 0,  1, 2, 'h22,  0,   0, 0, 0, 0,   0,  0,     0, 0, 0,     0};
        vecs[4]  = '{1, 0, 0, 0, 0,     0, 0,     0, 0,  1, 0, 'h00,  0,   0, 0, 0, 0,   0,  0,     0, 0, 0,     0};
        vecs[5]  = '{1, 0, 0, 0, 0,     0, 0,     0, 0,  1, 1, 'h11,  0,   1, 1, 1, 0,   5,  'h00,  0, 0, 0,     0};
        vecs[6]  = '{1, 0, 0, 0, 0,     0, 0,     0, 0,  0, 0, 0,     0,   1, 1, 1, 1,   6,  'h11,  0, 0, 0,     0};
        vecs[7]  = '{1, 0, 0, 0, 0,     0, 0,     0, 0,  0, 0, 0,     0,   1, 1, 1, 2,   7,  'h22,  0, 0, 0,     1};
        vecs[8]  = '{1, 0, 0, 0, 0,     0, 0,     0, 0,  0, 0, 0,     0,   0, 1, 1, 2,   7,  'h22,  0, 0, 0,     1};
        vecs[9]  = '{1, 1, 1, 0, 'h100, 0, 'h140, 0, 0,  0, 0, 0,     3,   0, 0, 0, 0,   0,  0,     0, 0, 0,     0};
        vecs[10] = '{1, 1, 0, 9, 'h104, 0, 0,     0, 0,  1, 3, 1,     4,   0, 0, 0, 0,   0,  0,     0, 0, 0,     0};
        vecs[11] = '{1, 0, 0, 0, 0,     0, 0,     0, 0,  0, 0, 0,     0,   1, 1, 0, 3,   0,  0,     0, 1, 'h140, 1};
        vecs[12] = '{1, 0, 0, 0, 0,     0, 0,     0, 0,  0, 0, 0,     0,   0, 0, 0, 0,   0,  0,     0, 0, 0,     1};
        vecs[13] = '{1, 1, 2, 1, 'h200, 0, 0,     0, 0,  0, 0, 0,     0,   0, 0, 0, 0,   0,  0,     0, 0, 0,     0};
        vecs[14] = '{1, 0, 0, 0, 0,     0, 0,     0, 0,  1, 0, 'h305, 0,   0, 0, 0, 0,   0,  0,     0, 0, 0,     0};
        vecs[15] = '{0, 0, 0, 0, 0,     0, 0,     0, 0,  0, 0, 0,     0,   0, 0, 0, 0,   0,  0,     0, 0, 0,     0};
        vecs[16] = '{1, 0, 0, 0, 0,     0, 0,     0, 0,  0, 0, 0,     0,   1, 1, 1, 0,   1,  'h204, 0, 1, 'h304, 1};
        vecs[17] = '{1, 1, 1, 0, 'h300, 1, 'h380, 1, 1,  0, 0, 0,     0,   0, 0, 0, 0,   0,  0,     0, 0, 0,     0};
        vecs[18] = '{1, 1, 3, 0, 'h304, 0, 0,     0, 0,  0, 0, 0,     1,   1, 1, 0, 0,   0,  0,     0, 0, 0,     0};
        vecs[19] = '{1, 0, 0, 0, 0,     0, 0,     0, 0,  2, 1, 0,     0,   0, 0, 0, 0,   0,  0,     0, 0, 0,     0};
        vecs[20] = '{1, 0, 0, 0, 0,     0, 0,     0, 0,  0, 0, 0,     0,   1, 1, 0, 1,   0,  0,     1, 0, 0,     1};

        // ---- reset state
        rdy   = 1'b1;
        rst_n = 1'b0;
        idle_inputs();
        #12;
        chk("reset isEmpty", rob_bus.isEmpty, 1);
        chk("reset isFull", rob_bus.isFull, 0);
        chk("reset commit_en", rob_bus.commit_en, 0);
        chk("reset flush_signal", rob_bus.flush_signal, 0);
        chk("reset alloc_index", rob_bus.alloc_index, 0);
        chk("reset commit_data", rob_bus.commit_data, 0);
        chk("reset flush_pc", rob_bus.flush_pc, 0);
        rst_n = 1'b1;

        // ---- async reset mid-run with 5 live entries and a commit in flight
        for (int i = 0; i < 5; i++) begin
            alloc_reg(5'(i + 1));
            tick();
        end
        idle_inputs();
        rob_bus.RS_update_en    = 1'b1;
        rob_bus.RS_update_index = 4'd0;
        rob_bus.RS_update_data  = 32'h5A;
        tick();
        idle_inputs();
        alloc_reg(5'd6);            // alloc + commit same cycle: count stays 5
        tick();
        idle_inputs();
        chk("midrun commit_en", rob_bus.commit_en, 1);
        chk("midrun commit_data", rob_bus.commit_data, 32'h5A);
        chk("midrun isEmpty", rob_bus.isEmpty, 0);
        rst_n = 1'b0;
        #1;
        chk("async reset commit_en", rob_bus.commit_en, 0);
        chk("async reset isEmpty", rob_bus.isEmpty, 1);
        chk("async reset alloc_index", rob_bus.alloc_index, 0);
        tick();
        rst_n = 1'b1;

        // ---- fill to 16, refuse the 17th, refuse alloc in a full+commit cycle, wrap tail to 0
        for (int i = 0; i < 16; i++) begin
            alloc_reg(5'd3);
            #1;
            chk($sformatf("fill alloc_index %0d", i), rob_bus.alloc_index, i[3:0]);
            tick();
        end
        idle_inputs();
        chk("fill isFull", rob_bus.isFull, 1);
        alloc_reg(5'd4);
        tick();
        chk("17th refused isFull", rob_bus.isFull, 1);
        rob_bus.RS_update_en    = 1'b1;
        rob_bus.RS_update_index = 4'd0;
        rob_bus.RS_update_data  = 32'h77;
        tick();
        rob_bus.RS_update_en = 1'b0;
        chk("full no commit yet", rob_bus.commit_en, 0);
        chk("full still isFull", rob_bus.isFull, 1);
        tick();                     // commit of tag 0 while alloc_en is held high
        chk("full commit_en", rob_bus.commit_en, 1);
        chk("full commit_index", rob_bus.commit_index, 0);
        chk("full commit_data", rob_bus.commit_data, 32'h77);
        chk("alloc refused during full commit", rob_bus.isFull, 0);
        #1;
        chk("wrapped alloc_index", rob_bus.alloc_index, 0);
        tick();
        chk("refill isFull", rob_bus.isFull, 1);
        do_reset();

        // ---- vector table: out-of-order write-back, branch/jalr flush, rdy_in hold, store
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i]);
            #1;
            if (vecs[i].a_en != 0)
                chk($sformatf("row%0d alloc_index", i), rob_bus.alloc_index, vecs[i].e_aidx);
            tick();
            chk($sformatf("row%0d commit_en", i), rob_bus.commit_en, vecs[i].e_ce);
            chk($sformatf("row%0d commit_store_en", i), rob_bus.commit_store_en, vecs[i].e_st);
            chk($sformatf("row%0d flush_signal", i), rob_bus.flush_signal, vecs[i].e_fl);
            chk($sformatf("row%0d isEmpty", i), rob_bus.isEmpty, vecs[i].e_empty);
            if (vecs[i].chk_c != 0) begin
                chk($sformatf("row%0d commit_index", i), rob_bus.commit_index, vecs[i].e_cidx);
                chk($sformatf("row%0d commit_rd", i), rob_bus.commit_rd, vecs[i].e_crd);
            end
            if (vecs[i].chk_d != 0)
                chk($sformatf("row%0d commit_data", i), rob_bus.commit_data, vecs[i].e_cdat);
            if (vecs[i].e_fl != 0)
                chk($sformatf("row%0d flush_pc", i), rob_bus.flush_pc, vecs[i].e_fpc);
        end
        do_reset();

        // ---- query bypass and RS-over-LSB priority
        for (int i = 0; i < 4; i++) begin
            alloc_reg(5'(i + 10));
            tick();
        end
        idle_inputs();
        rob_bus.RS_update_en     = 1'b1;
        rob_bus.RS_update_index  = 4'd3;
        rob_bus.RS_update_data   = 32'hAB;
        rob_bus.LSB_update_en    = 1'b1;
        rob_bus.LSB_update_index = 4'd1;
        rob_bus.LSB_update_data  = 32'hCD;
        rob_bus.query_j_index    = 4'd3;
        rob_bus.query_k_index    = 4'd2;
        #1;
        chk("bypass j ready", rob_bus.query_j_ready, 1);
        chk("bypass j data", rob_bus.query_j_data, 32'hAB);
        chk("not ready k ready", rob_bus.query_k_ready, 0);
        chk("not ready k data", rob_bus.query_k_data, 0);
        rob_bus.query_k_index = 4'd1;
        #1;
        chk("LSB bypass k ready", rob_bus.query_k_ready, 1);
        chk("LSB bypass k data", rob_bus.query_k_data, 32'hCD);
        tick();
        idle_inputs();
        rob_bus.query_j_index = 4'd3;
        #1;
        chk("stored j ready", rob_bus.query_j_ready, 1);
        chk("stored j data", rob_bus.query_j_data, 32'hAB);
        rob_bus.RS_update_en     = 1'b1;
        rob_bus.RS_update_index  = 4'd2;
        rob_bus.RS_update_data   = 32'h55;
        rob_bus.LSB_update_en    = 1'b1;
        rob_bus.LSB_update_index = 4'd2;
        rob_bus.LSB_update_data  = 32'h66;
        rob_bus.query_k_index    = 4'd2;
        #1;
        chk("dual bypass RS first", rob_bus.query_k_data, 32'h55);
        tick();
        idle_inputs();
        rob_bus.query_k_index = 4'd2;
        #1;
        chk("dual write RS wins ready", rob_bus.query_k_ready, 1);
        chk("dual write RS wins data", rob_bus.query_k_data, 32'h55);
        chk("head not ready no commit", rob_bus.commit_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
